// File: rtl/modport_pkg.sv
// Shared types and sizing for the dictionary compress/decompress unit.
package modport_pkg;

  localparam int DATA_W = 80;
  localparam int CODE_W = 8;
  localparam int DEPTH  = 2 ** CODE_W;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_COMP   = 2'b01,
    CMD_DECOMP = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RSP_NONE   = 2'b00,
    RSP_COMP   = 2'b01,
    RSP_DECOMP = 2'b10,
    RSP_ERR    = 2'b11
  } resp_e;

endpackage

// File: rtl/modport_dict.sv
// Dictionary storage: DEPTH words plus a fill count. Entries below the count
// are valid. Offers a parallel lookup, an indexed read and an allocate strobe
// that appends the lookup word at the current count.
module modport_dict
  import modport_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] lookup_data,
  output logic              hit,
  output logic [CODE_W-1:0] hit_index,
  input  logic [CODE_W-1:0] rd_index,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              alloc,
  output logic [CODE_W-1:0] alloc_code,
  output logic              full
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CODE_W:0]   count_q;
  logic [CODE_W:0]   count_d;
  logic [DEPTH-1:0]  match;
  logic              alloc_en;

  // One comparator per entry; entries at or above the count never match.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      localparam logic [CODE_W:0] IDX = gi;
      assign match[gi] = (IDX < count_q) && (mem_q[gi] == lookup_data);
    end
  endgenerate

  // Priority encode the match vector so the lowest index wins.
  always_comb begin
    hit       = |match;
    hit_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) hit_index = CODE_W'(i);
    end
  end

  // The count never exceeds DEPTH, so its top bit alone flags a full dictionary.
  assign full       = count_q[CODE_W];
  assign alloc_code = count_q[CODE_W-1:0];
  assign alloc_en   = alloc && !full;
  assign rd_valid   = ({1'b0, rd_index} < count_q);
  assign rd_data    = mem_q[rd_index];

  // Next count: bump on every accepted allocation.
  always_comb begin
    count_d = count_q;
    if (alloc_en) count_d = count_q + 1'b1;
  end

  // Count register; reset empties the dictionary.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Entry write; a reset in the same cycle cancels the allocation.
  always_ff @(posedge clk) begin
    if (!reset && alloc_en) mem_q[alloc_code] <= lookup_data;
  end

endmodule

// File: rtl/modport_codec.sv
// Top level: decodes one command per clock against the dictionary and
// registers the code/word results and a one-cycle response.
module modport_codec
  import modport_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CODE_W-1:0] compressed_in,
  input  logic [1:0]        command,
  output logic [CODE_W-1:0] compressed_out,
  output logic [DATA_W-1:0] decompressed_out,
  output logic [1:0]        response
);

  logic              hit;
  logic [CODE_W-1:0] hit_index;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              alloc;
  logic [CODE_W-1:0] alloc_code;
  logic              full;

  logic [CODE_W-1:0] comp_q, comp_d;
  logic [DATA_W-1:0] decomp_q, decomp_d;
  resp_e             resp_q, resp_d;

  modport_dict u_dict (
    .clk         (clk),
    .reset       (reset),
    .lookup_data (data_in),
    .hit         (hit),
    .hit_index   (hit_index),
    .rd_index    (compressed_in),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .alloc       (alloc),
    .alloc_code  (alloc_code),
    .full        (full)
  );

  // Command decode: data outputs hold unless a successful command updates them.
  always_comb begin
    comp_d   = comp_q;
    decomp_d = decomp_q;
    resp_d   = RSP_NONE;
    alloc    = 1'b0;
    case (cmd_e'(command))
      CMD_NOP: resp_d = RSP_NONE;
      CMD_COMP: begin
        if (hit) begin
          comp_d = hit_index;
          resp_d = RSP_COMP;
        end else if (!full) begin
          alloc  = 1'b1;
          comp_d = alloc_code;
          resp_d = RSP_COMP;
        end else begin
          resp_d = RSP_ERR;
        end
      end
      CMD_DECOMP: begin
        if (rd_valid) begin
          decomp_d = rd_data;
          resp_d   = RSP_DECOMP;
        end else begin
          resp_d = RSP_ERR;
        end
      end
      CMD_RSVD: resp_d = RSP_ERR;
      default:  resp_d = RSP_ERR;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      comp_q   <= '0;
      decomp_q <= '0;
      resp_q   <= RSP_NONE;
    end else begin
      comp_q   <= comp_d;
      decomp_q <= decomp_d;
      resp_q   <= resp_d;
    end
  end

  assign compressed_out   = comp_q;
  assign decompressed_out = decomp_q;
  assign response         = resp_q;

endmodule

// File: tb/tb_modport_codec.sv
// Bench for modport_codec: queue-based dictionary model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_modport_codec;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] data_in;
  logic [7:0]  compressed_in;
  logic [1:0]  command;
  logic [7:0]  compressed_out;
  logic [79:0] decompressed_out;
  logic [1:0]  response;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  modport_codec dut (
    .clk              (clk),
    .reset            (reset),
    .data_in          (data_in),
    .compressed_in    (compressed_in),
    .command          (command),
    .compressed_out   (compressed_out),
    .decompressed_out (decompressed_out),
    .response         (response)
  );

  always #5 clk = ~clk;

  // Reference model: a list of words, position in the list is the code.
  logic [79:0] mdl_dict[$];
  logic [7:0]  exp_comp   = '0;
  logic [79:0] exp_decomp = '0;
  logic [1:0]  exp_resp   = '0;

  always @(posedge clk) begin
    int idx;
    if (reset) begin
      mdl_dict.delete();
      exp_comp   = '0;
      exp_decomp = '0;
      exp_resp   = 2'b00;
    end else begin
      case (command)
        2'b00: exp_resp = 2'b00;
        2'b01: begin
          idx = -1;
          foreach (mdl_dict[k]) if (idx < 0 && mdl_dict[k] == data_in) idx = k;
          if (idx >= 0) begin
            exp_comp = 8'(idx);
            exp_resp = 2'b01;
          end else if (mdl_dict.size() < 256) begin
            exp_comp = 8'(mdl_dict.size());
            mdl_dict.push_back(data_in);
            exp_resp = 2'b01;
          end else begin
            exp_resp = 2'b11;
          end
        end
        2'b10: begin
          if (int'(compressed_in) < mdl_dict.size()) begin
            exp_decomp = mdl_dict[compressed_in];
            exp_resp   = 2'b10;
          end else begin
            exp_resp = 2'b11;
          end
        end
        default: exp_resp = 2'b11;
      endcase
    end
  end

  // Per-cycle compare of every output against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (response !== exp_resp || compressed_out !== exp_comp ||
          decompressed_out !== exp_decomp) begin
        n_err++;
        $display("FAIL model t=%0t: got resp=%b code=%h word=%h expected resp=%b code=%h word=%h",
                 $time, response, compressed_out, decompressed_out,
                 exp_resp, exp_comp, exp_decomp);
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one command for one edge, return at the following falling edge.
  task automatic step(input logic [1:0] c, input logic [79:0] d, input logic [7:0] k);
    command       = c;
    data_in       = d;
    compressed_in = k;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    step(2'b00, '0, '0);
    step(2'b01, 80'h99, '0);
    reset  = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step(2'b00, '0, '0);
      chk("nop_resp", 80'(response), 80'h0);
      chk("nop_code", 80'(compressed_out), 80'h0);
      chk("nop_word", decompressed_out, 80'h0);
    end

    step(2'b01, 80'h1234, '0);
    chk("comp1234_code", 80'(compressed_out), 80'h00);
    chk("comp1234_resp", 80'(response), 80'h1);
    step(2'b00, '0, '0);
    chk("resp_clears", 80'(response), 80'h0);
    step(2'b01, 80'hABCD, '0);
    chk("compABCD_code", 80'(compressed_out), 80'h01);
    step(2'b01, 80'h1234, '0);
    chk("hit1234_code", 80'(compressed_out), 80'h00);
    chk("hit1234_resp", 80'(response), 80'h1);
    step(2'b10, '0, 8'h01);
    chk("decomp1_word", decompressed_out, 80'hABCD);
    chk("decomp1_resp", 80'(response), 80'h2);
    step(2'b10, '0, 8'h05);
    chk("decomp5_resp", 80'(response), 80'h3);
    chk("decomp5_hold", decompressed_out, 80'hABCD);
    step(2'b10, '0, 8'h02);
    chk("count_is_2", 80'(response), 80'h3);

    step(2'b11, 80'h1, 8'h0);
    chk("rsvd_resp", 80'(response), 80'h3);
    chk("rsvd_hold", 80'(compressed_out), 80'h00);
    step(2'b01, 80'h55, '0);
    chk("b2b_code", 80'(compressed_out), 80'h02);
    step(2'b10, '0, 8'h02);
    chk("b2b_word", decompressed_out, 80'h55);
    chk("b2b_resp", 80'(response), 80'h2);

    // Random traffic from a small word pool so hits and misses both occur.
    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), 80'($urandom_range(0, 40)), 8'($urandom_range(0, 47)));

    // Fill the dictionary completely.
    reset = 1'b1;
    step(2'b00, '0, '0);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step(2'b01, 80'(i), '0);
      if (response !== 2'b01 || compressed_out !== 8'(i)) begin
        n_cmp++;
        n_err++;
        $display("FAIL fill_%0d: got %h/%b expected %h/01", i, compressed_out, response, 8'(i));
      end else begin
        n_cmp++;
      end
    end
    step(2'b01, 80'hFFFF, '0);
    chk("full_resp", 80'(response), 80'h3);
    chk("full_hold", 80'(compressed_out), 80'hFF);
    step(2'b01, 80'h7, '0);
    chk("full_hit_code", 80'(compressed_out), 80'h07);
    chk("full_hit_resp", 80'(response), 80'h1);
    step(2'b10, '0, 8'hFF);
    chk("decompFF_word", decompressed_out, 80'hFF);
    chk("decompFF_resp", 80'(response), 80'h2);
    for (int i = 0; i < 200; i++)
      step(2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1) ? 80'($urandom_range(0, 300)) : {$urandom, $urandom, 16'($urandom)},
           8'($urandom));

    // Reset during a compress: nothing is allocated.
    reset = 1'b1;
    step(2'b01, 80'h4242, '0);
    reset = 1'b0;
    chk("rst_resp", 80'(response), 80'h0);
    chk("rst_code", 80'(compressed_out), 80'h0);
    chk("rst_word", decompressed_out, 80'h0);
    step(2'b10, '0, 8'h00);
    chk("rst_empty", 80'(response), 80'h3);
    step(2'b01, 80'h0, '0);
    chk("zero_word_code", 80'(compressed_out), 80'h00);
    chk("zero_word_resp", 80'(response), 80'h1);
    step(2'b00, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
